// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI-over-SPI note master.
package midi_pkg;

   localparam logic [7:0]  MIDI_NOTE_ON  = 8'h90;
   localparam logic [7:0]  MIDI_NOTE_OFF = 8'h80;
   localparam int unsigned NUM_NOTES     = 88;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StSetup,
      StShift,
      StHold,
      StGap
   } midi_state_e;

   typedef struct packed {
      logic       note_on;
      logic [6:0] note;
      logic [6:0] velocity;
   } midi_event_t;

   // Byte idx of the 3-byte frame: status, note, velocity.
   function automatic logic [7:0] frame_byte(input midi_event_t ev, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = ev.note_on ? MIDI_NOTE_ON : MIDI_NOTE_OFF;
         2'd1:    b = {1'b0, ev.note};
         default: b = {1'b0, ev.velocity};
      endcase
      return b;
   endfunction

endpackage

// File: rtl/midi_spi_master_if.sv
// Note-event handshake between a sender and the MIDI SPI master.
interface midi_spi_master_if;

   logic       ev_valid;
   logic       ev_ready;
   logic       ev_note_on;
   logic [6:0] ev_note;
   logic [6:0] ev_velocity;

   modport master (
      output ev_valid,
      output ev_note_on,
      output ev_note,
      output ev_velocity,
      input  ev_ready
   );

   modport slave (
      input  ev_valid,
      input  ev_note_on,
      input  ev_note,
      input  ev_velocity,
      output ev_ready
   );

endinterface

// File: rtl/midi_event_fifo.sv
// Synchronous event FIFO with count-based full/empty and show-ahead read data.
module midi_event_fifo
   import midi_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        push,
   input  midi_event_t wdata,
   input  logic        pop,
   output midi_event_t rdata,
   output logic        full,
   output logic        empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   midi_event_t   mem [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr_q];

   // Pointers and occupancy; push+pop together leaves the count unchanged.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage array; contents are don't-care while empty so it carries no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/midi_spi_master.sv
// Buffers MIDI note events and serialises each as a 3-byte SPI mode-0 frame.
module midi_spi_master
   import midi_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned GAP_CYCLES = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     nreset,
   midi_spi_master_if.slave         ev,
   output logic                     ev_dropped,
   output logic                     busy,
   output logic                     frame_done,
   output logic                     spi_sclk,
   output logic                     spi_mosi,
   output logic                     spi_nss,
   input  logic                     spi_miso
);

   localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
   localparam logic [7:0] GapLast = 8'(GAP_CYCLES - 1);

   logic        ready_q;
   logic        drop_q;
   logic        accept;
   logic        note_ok;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_pop;
   midi_event_t in_ev;
   midi_event_t head_ev;
   midi_event_t frame_q;
   logic [7:0]  first_byte;
   logic [7:0]  next_byte;

   midi_state_e state_q;
   logic [7:0]  cnt_q;
   logic [2:0]  bit_q;
   logic [1:0]  byte_q;
   logic [7:0]  shreg_q;
   logic        sclk_q;
   logic        mosi_q;
   logic        nss_q;
   logic        done_q;

   // MISO is not part of this write-only link.
   logic unused_miso;
   assign unused_miso = spi_miso;

   assign ev.ev_ready = ready_q & ~fifo_full;
   assign accept      = ev.ev_valid & ev.ev_ready;
   assign note_ok     = (ev.ev_note < 7'(NUM_NOTES));
   assign fifo_pop    = (state_q == StLoad);
   assign first_byte  = frame_byte(head_ev, 2'd0);
   assign next_byte   = frame_byte(frame_q, byte_q + 2'd1);

   assign ev_dropped  = drop_q;
   assign frame_done  = done_q;
   assign spi_sclk    = sclk_q;
   assign spi_mosi    = mosi_q;
   assign spi_nss     = nss_q;
   assign busy        = ~fifo_empty | (state_q != StIdle);

   // Pack the offered event into the FIFO entry layout.
   always_comb begin
      in_ev          = '0;
      in_ev.note_on  = ev.ev_note_on;
      in_ev.note     = ev.ev_note;
      in_ev.velocity = ev.ev_velocity;
   end

   midi_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .nreset (nreset),
      .push   (accept & note_ok),
      .wdata  (in_ev),
      .pop    (fifo_pop),
      .rdata  (head_ev),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   // Ready comes up one edge after reset release; out-of-range notes are
   // accepted but only reported, never queued.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         ready_q <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         drop_q  <= accept & ~note_ok;
      end
   end

   // Frame sequencer; all SPI pins are driven straight from these registers.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shreg_q <= '0;
         frame_q <= '0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         nss_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (!fifo_empty) state_q <= StLoad;
            end
            StLoad: begin
               frame_q <= head_ev;
               shreg_q <= first_byte;
               byte_q  <= 2'd0;
               cnt_q   <= '0;
               nss_q   <= 1'b0;
               mosi_q  <= first_byte[7];
               sclk_q  <= 1'b0;
               state_q <= StSetup;
            end
            StSetup: begin
               if (cnt_q == DivLast) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  sclk_q  <= 1'b1;
                  state_q <= StShift;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StShift: begin
               if (cnt_q == DivLast) begin
                  cnt_q <= '0;
                  if (sclk_q) begin
                     // Falling edge: the only place MOSI advances.
                     sclk_q  <= 1'b0;
                     shreg_q <= {shreg_q[6:0], 1'b0};
                     mosi_q  <= shreg_q[6];
                  end else if (bit_q == 3'd7) begin
                     state_q <= StHold;
                  end else begin
                     sclk_q <= 1'b1;
                     bit_q  <= bit_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StHold: begin
               if (cnt_q == DivLast) begin
                  cnt_q   <= '0;
                  nss_q   <= 1'b1;
                  mosi_q  <= 1'b0;
                  state_q <= StGap;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StGap: begin
               if (cnt_q == GapLast) begin
                  cnt_q <= '0;
                  if (byte_q == 2'd2) begin
                     done_q  <= 1'b1;
                     state_q <= StIdle;
                  end else begin
                     byte_q  <= byte_q + 2'd1;
                     shreg_q <= next_byte;
                     mosi_q  <= next_byte[7];
                     nss_q   <= 1'b0;
                     state_q <= StSetup;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_midi_spi_master.sv
// Self-checking bench for midi_spi_master with an SPI-to-MIDI receiver model.
module tb_midi_spi_master;
   import midi_pkg::*;

   localparam int unsigned CLK_DIV    = 4;
   localparam int unsigned GAP_CYCLES = 8;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int          FRAME_LEN  = 3 * (18 * CLK_DIV + GAP_CYCLES);

   logic clk = 1'b0;
   logic nreset = 1'b0;
   logic ev_dropped, busy, frame_done, spi_sclk, spi_mosi, spi_nss;
   logic spi_miso = 1'b1;

   midi_spi_master_if ev_bus ();

   midi_spi_master #(
      .CLK_DIV    (CLK_DIV),
      .GAP_CYCLES (GAP_CYCLES),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .nreset     (nreset),
      .ev         (ev_bus),
      .ev_dropped (ev_dropped),
      .busy       (busy),
      .frame_done (frame_done),
      .spi_sclk   (spi_sclk),
      .spi_mosi   (spi_mosi),
      .spi_nss    (spi_nss),
      .spi_miso   (spi_miso)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Receiver model and pin monitor, sampled mid-cycle.
   logic [7:0]  rx_q[$];
   int          fall_q[$];
   int          done_q[$];
   int          drop_q[$];
   midi_event_t sent_q[$];
   int          stab_err = 0;
   int          sclk_err = 0;
   int          nbits = 0;
   logic [7:0]  sh = '0;
   logic        p_sclk = 1'b0;
   logic        p_nss = 1'b1;
   logic        p_mosi = 1'b0;

   always @(negedge clk) begin
      if (!nreset) begin
         nbits = 0;
      end else begin
         if (spi_nss === 1'b0 && p_nss === 1'b1) fall_q.push_back(cyc);
         if (spi_nss === 1'b1) begin
            nbits = 0;
            if (spi_sclk !== 1'b0) sclk_err++;
         end else if (spi_sclk === 1'b1 && p_sclk === 1'b0) begin
            sh = {sh[6:0], spi_mosi};
            nbits++;
            if (nbits == 8) begin
               rx_q.push_back(sh);
               nbits = 0;
            end
         end
         if (spi_sclk === 1'b1 && p_sclk === 1'b1 && spi_mosi !== p_mosi) stab_err++;
         if (frame_done === 1'b1) done_q.push_back(cyc);
         if (ev_dropped === 1'b1) drop_q.push_back(cyc);
      end
      p_sclk = spi_sclk;
      p_nss  = spi_nss;
      p_mosi = spi_mosi;
   end

   function automatic midi_event_t rx_decode(input logic [7:0] s, input logic [7:0] n,
                                             input logic [7:0] v);
      midi_event_t e;
      e.note_on  = (s == 8'h90);
      e.note     = n[6:0];
      e.velocity = v[6:0];
      return e;
   endfunction

   function automatic bit rx_framing_ok(input logic [7:0] s, input logic [7:0] n,
                                        input logic [7:0] v);
      return (s == 8'h90 || s == 8'h80) && !n[7] && !v[7];
   endfunction

   task automatic clear_mon();
      rx_q.delete();
      fall_q.delete();
      done_q.delete();
      drop_q.delete();
      sent_q.delete();
      stab_err = 0;
      sclk_err = 0;
   endtask

   task automatic send(input logic on, input logic [6:0] n, input logic [6:0] v,
                       output int acc, output bit ok);
      int t;
      midi_event_t e;
      t = 0;
      @(negedge clk);
      ev_bus.ev_valid    = 1'b1;
      ev_bus.ev_note_on  = on;
      ev_bus.ev_note     = n;
      ev_bus.ev_velocity = v;
      while (ev_bus.ev_ready !== 1'b1 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      ok  = (ev_bus.ev_ready === 1'b1);
      acc = cyc + 1;
      @(posedge clk);
      #1 ev_bus.ev_valid = 1'b0;
      e.note_on  = on;
      e.note     = n;
      e.velocity = v;
      if (ok && n < 7'd88) sent_q.push_back(e);
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      int t;
      t = 0;
      ok = 1'b0;
      while (t < budget) begin
         @(negedge clk);
         t++;
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [6:0] got;
      nreset = 1'b0;
      repeat (3) @(negedge clk);
      got = {spi_nss, spi_sclk, spi_mosi, ev_bus.ev_ready, busy, frame_done, ev_dropped};
      vectors++;
      if (got !== 7'b1000000) begin
         $display("FAIL reset_outputs: got %b want 1000000 (nss,sclk,mosi,rdy,busy,done,drop)",
                  got);
         miscompares++;
      end
      nreset = 1'b1;
      #1;
      vectors++;
      if (ev_bus.ev_ready !== 1'b0) begin
         $display("FAIL reset_ready_early: got %b want 0", ev_bus.ev_ready);
         miscompares++;
      end
      @(negedge clk);
      vectors++;
      if (ev_bus.ev_ready !== 1'b1) begin
         $display("FAIL reset_ready_rise: got %b want 1", ev_bus.ev_ready);
         miscompares++;
      end
   endtask

   task automatic test_basic_note_on();
      int acc;
      bit ok;
      logic [7:0] exp_b [3];
      logic [7:0] got;
      exp_b[0] = 8'h90;
      exp_b[1] = 8'h3C;
      exp_b[2] = 8'h64;
      clear_mon();
      send(1'b1, 7'd60, 7'd100, acc, ok);
      wait_idle(2000, ok);
      vectors++;
      if (!ok) begin
         $display("FAIL basic_timeout: busy still %b", busy);
         miscompares++;
      end
      vectors++;
      if (fall_q.size() < 1 || fall_q[0] != acc + 2) begin
         $display("FAIL basic_latency: nss fell at %0d want %0d",
                  (fall_q.size() > 0) ? fall_q[0] : -1, acc + 2);
         miscompares++;
      end
      vectors++;
      if (done_q.size() != 1 || fall_q.size() < 1 || done_q[0] - fall_q[0] != FRAME_LEN) begin
         $display("FAIL basic_frame_len: %0d done pulses, len %0d want 1 pulse len %0d",
                  done_q.size(),
                  (done_q.size() > 0 && fall_q.size() > 0) ? done_q[0] - fall_q[0] : -1,
                  FRAME_LEN);
         miscompares++;
      end
      for (int i = 0; i < 3; i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         vectors++;
         if (got !== exp_b[i]) begin
            $display("FAIL basic_byte%0d: got %h want %h", i, got, exp_b[i]);
            miscompares++;
         end
      end
   endtask

   task automatic test_note_off_zero();
      int acc;
      bit ok;
      logic [7:0] got;
      clear_mon();
      send(1'b0, 7'd0, 7'd0, acc, ok);
      wait_idle(2000, ok);
      vectors++;
      if (rx_q.size() != 3) begin
         $display("FAIL off_byte_count: got %0d want 3", rx_q.size());
         miscompares++;
      end
      for (int i = 0; i < 3; i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         vectors++;
         if (got !== ((i == 0) ? 8'h80 : 8'h00)) begin
            $display("FAIL off_byte%0d: got %h want %h", i, got, (i == 0) ? 8'h80 : 8'h00);
            miscompares++;
         end
      end
      vectors++;
      if (stab_err != 0) begin
         $display("FAIL off_mosi_stable: %0d changes during sclk high, want 0", stab_err);
         miscompares++;
      end
   endtask

   task automatic test_back_to_back();
      int acc [6];
      bit ok;
      int bad;
      logic [6:0] n;
      logic [6:0] v;
      midi_event_t d;
      clear_mon();
      for (int i = 0; i < 6; i++) begin
         n = 7'($urandom_range(0, 87));
         v = 7'($urandom_range(0, 127));
         if (i == 5) begin
            @(negedge clk);
            vectors++;
            if (ev_bus.ev_ready !== 1'b0) begin
               $display("FAIL b2b_full_ready: got %b want 0", ev_bus.ev_ready);
               miscompares++;
            end
         end
         send(1'($urandom_range(0, 1)), n, v, acc[i], ok);
         vectors++;
         if (!ok || (i < 5 && acc[i] != acc[0] + i)) begin
            $display("FAIL b2b_accept%0d: ok %0d at %0d want at %0d", i, ok, acc[i], acc[0] + i);
            miscompares++;
         end
      end
      vectors++;
      if (done_q.size() < 1 || acc[5] != done_q[0] + 3) begin
         $display("FAIL b2b_sixth_accept: at %0d want %0d", acc[5],
                  (done_q.size() > 0) ? done_q[0] + 3 : -1);
         miscompares++;
      end
      wait_idle(5000, ok);
      vectors++;
      if (!ok || done_q.size() != 6 || rx_q.size() != 18) begin
         $display("FAIL b2b_frames: idle %0d done %0d bytes %0d want 1 6 18", ok,
                  done_q.size(), rx_q.size());
         miscompares++;
      end
      vectors++;
      if (fall_q.size() < 4 || done_q.size() < 1 || fall_q[3] - done_q[0] != 2) begin
         $display("FAIL b2b_spacing: got %0d want 2",
                  (fall_q.size() > 3 && done_q.size() > 0) ? fall_q[3] - done_q[0] : -1);
         miscompares++;
      end
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (3 * i + 2 < rx_q.size()) begin
            d = rx_decode(rx_q[3*i], rx_q[3*i+1], rx_q[3*i+2]);
            if (d !== sent_q[i] || !rx_framing_ok(rx_q[3*i], rx_q[3*i+1], rx_q[3*i+2])) bad++;
         end else begin
            bad++;
         end
      end
      vectors++;
      if (bad != 0) begin
         $display("FAIL b2b_order: %0d of 6 frames wrong, want 0", bad);
         miscompares++;
      end
   endtask

   task automatic test_drop();
      int acc;
      bit ok;
      bit busy_seen;
      clear_mon();
      busy_seen = 1'b0;
      send(1'b1, 7'($urandom_range(88, 127)), 7'($urandom_range(0, 127)), acc, ok);
      repeat (30) begin
         @(negedge clk);
         if (busy !== 1'b0) busy_seen = 1'b1;
      end
      vectors++;
      if (!ok || drop_q.size() != 1 || drop_q[0] != acc) begin
         $display("FAIL drop_pulse: ok %0d pulses %0d at %0d want 1 pulse at %0d", ok,
                  drop_q.size(), (drop_q.size() > 0) ? drop_q[0] : -1, acc);
         miscompares++;
      end
      vectors++;
      if (fall_q.size() != 0 || busy_seen) begin
         $display("FAIL drop_quiet: nss falls %0d busy_seen %0d want 0 0", fall_q.size(),
                  busy_seen);
         miscompares++;
      end
   endtask

   task automatic test_loopback();
      int acc;
      bit ok;
      int bad;
      int bad_len;
      midi_event_t d;
      clear_mon();
      send(1'b1, 7'd87, 7'd127, acc, ok);
      for (int i = 1; i < 20; i++) begin
         repeat ($urandom_range(0, 300)) @(negedge clk);
         send(1'($urandom_range(0, 1)), 7'($urandom_range(0, 87)),
              7'($urandom_range(0, 127)), acc, ok);
      end
      wait_idle(20000, ok);
      vectors++;
      if (!ok || done_q.size() != 20 || rx_q.size() != 60 || sent_q.size() != 20) begin
         $display("FAIL loop_counts: idle %0d done %0d bytes %0d sent %0d want 1 20 60 20",
                  ok, done_q.size(), rx_q.size(), sent_q.size());
         miscompares++;
      end
      bad = 0;
      bad_len = 0;
      for (int i = 0; i < 20; i++) begin
         if (3 * i + 2 < rx_q.size() && i < sent_q.size()) begin
            d = rx_decode(rx_q[3*i], rx_q[3*i+1], rx_q[3*i+2]);
            if (d !== sent_q[i] || !rx_framing_ok(rx_q[3*i], rx_q[3*i+1], rx_q[3*i+2])) bad++;
         end else begin
            bad++;
         end
         if (i >= done_q.size() || 3 * i >= fall_q.size() ||
             done_q[i] - fall_q[3*i] != FRAME_LEN) bad_len++;
      end
      vectors++;
      if (bad != 0) begin
         $display("FAIL loop_decode: %0d of 20 events wrong, want 0", bad);
         miscompares++;
      end
      vectors++;
      if (bad_len != 0) begin
         $display("FAIL loop_frame_len: %0d frames not %0d cycles, want 0", bad_len, FRAME_LEN);
         miscompares++;
      end
      vectors++;
      if (stab_err != 0 || sclk_err != 0) begin
         $display("FAIL loop_pins: mosi changes %0d sclk-while-deselected %0d want 0 0",
                  stab_err, sclk_err);
         miscompares++;
      end
   endtask

   task automatic test_reset_mid_frame();
      int acc;
      int t;
      int falls;
      bit ok;
      bit busy_seen;
      logic [7:0] got;
      logic [7:0] exp_b [3];
      logic [6:0] n;
      logic [6:0] v;
      clear_mon();
      send(1'b1, 7'($urandom_range(0, 87)), 7'($urandom_range(0, 127)), acc, ok);
      send(1'b0, 7'($urandom_range(0, 87)), 7'($urandom_range(0, 127)), acc, ok);
      t = 0;
      while (!(rx_q.size() == 2 && nbits == 4 && spi_sclk === 1'b1) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      vectors++;
      if (t >= 2000) begin
         $display("FAIL rst_mid_reach: never reached bit 3 of byte 2, got %0d bytes",
                  rx_q.size());
         miscompares++;
      end
      #2 nreset = 1'b0;
      #1;
      vectors++;
      if (spi_nss !== 1'b1 || spi_sclk !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL rst_mid_async: nss %b sclk %b busy %b want 1 0 0", spi_nss, spi_sclk,
                  busy);
         miscompares++;
      end
      @(negedge clk);
      nreset = 1'b1;
      falls = fall_q.size();
      busy_seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (busy !== 1'b0) busy_seen = 1'b1;
      end
      vectors++;
      if (busy_seen || fall_q.size() != falls) begin
         $display("FAIL rst_mid_fifo_empty: busy_seen %0d new nss falls %0d want 0 0",
                  busy_seen, fall_q.size() - falls);
         miscompares++;
      end
      clear_mon();
      n = 7'($urandom_range(0, 87));
      v = 7'($urandom_range(0, 127));
      exp_b[0] = 8'h90;
      exp_b[1] = {1'b0, n};
      exp_b[2] = {1'b0, v};
      send(1'b1, n, v, acc, ok);
      wait_idle(2000, ok);
      vectors++;
      if (fall_q.size() != 3 || fall_q[0] != acc + 2 || done_q.size() != 1 ||
          done_q[0] - fall_q[0] != FRAME_LEN) begin
         $display("FAIL rst_mid_clean_frame: falls %0d done %0d want 3 1 with len %0d",
                  fall_q.size(), done_q.size(), FRAME_LEN);
         miscompares++;
      end
      for (int i = 0; i < 3; i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         vectors++;
         if (got !== exp_b[i]) begin
            $display("FAIL rst_mid_byte%0d: got %h want %h", i, got, exp_b[i]);
            miscompares++;
         end
      end
   endtask

   initial begin
      ev_bus.ev_valid    = 1'b0;
      ev_bus.ev_note_on  = 1'b0;
      ev_bus.ev_note     = '0;
      ev_bus.ev_velocity = '0;
      test_reset();
      test_basic_note_on();
      test_note_off_zero();
      test_back_to_back();
      test_drop();
      test_loopback();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, %0d miscompares so far",
               miscompares);
      $fatal(1, "watchdog expired");
   end

endmodule
